// File: rtl/hz_pkg.sv
// Shared definitions for the pipeline hazard scheduler:
// operand timing codes, forward selects and the scoreboard slot type.
package hz_pkg;

  localparam logic [1:0] TUSE_NONE = 2'd3;

  localparam logic [1:0] TNEW_LINK = 2'd0;
  localparam logic [1:0] TNEW_ALU  = 2'd1;
  localparam logic [1:0] TNEW_LOAD = 2'd2;

  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_E  = 2'd1;
  localparam logic [1:0] FWD_M  = 2'd2;
  localparam logic [1:0] FWD_W  = 2'd3;

  typedef struct packed {
    logic [4:0] dst;
    logic [1:0] tnew;
  } slot_t;

  function automatic logic [1:0] tnew_dec(input logic [1:0] t);
    return (t == TNEW_LINK) ? TNEW_LINK : t - 2'd1;
  endfunction

endpackage

// File: rtl/hazard_sched_if.sv
// Decode-stage hazard query and pipeline control bundle.
// master drives the D-stage fields, slave answers with controls.
interface hazard_sched_if;

  logic [4:0] d_rs;
  logic [4:0] d_rt;
  logic [1:0] d_tuse_rs;
  logic [1:0] d_tuse_rt;
  logic [4:0] d_dst;
  logic [1:0] d_tnew;
  logic       d_md_start;
  logic       d_md_div;
  logic       d_md_use;

  logic       pc_en;
  logic       d_en;
  logic       e_clr;
  logic [1:0] fwd_rs_d;
  logic [1:0] fwd_rt_d;
  logic       md_busy;

  modport master (
    output d_rs, d_rt, d_tuse_rs, d_tuse_rt,
    output d_dst, d_tnew,
    output d_md_start, d_md_div, d_md_use,
    input  pc_en, d_en, e_clr,
    input  fwd_rs_d, fwd_rt_d, md_busy
  );

  modport slave (
    input  d_rs, d_rt, d_tuse_rs, d_tuse_rt,
    input  d_dst, d_tnew,
    input  d_md_start, d_md_div, d_md_use,
    output pc_en, d_en, e_clr,
    output fwd_rs_d, fwd_rt_d, md_busy
  );

endinterface

// File: rtl/hz_slot.sv
// One scoreboard entry: destination register and
// remaining result latency of an in-flight instruction.
module hz_slot
  import hz_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  bubble,
  input  logic  dec,
  input  slot_t d,
  output slot_t q
);

  // Take the upstream entry, aging it when it moves down the pipe
  always_ff @(posedge clk) begin
    if (!reset) begin
      q <= '0;
    end else if (bubble) begin
      q <= '0;
    end else begin
      q.dst  <= d.dst;
      q.tnew <= dec ? tnew_dec(d.tnew) : d.tnew;
    end
  end

endmodule

// File: rtl/hazard_sched.sv
// Stall, bubble and forward-select generation for the
// five-stage core, plus the mult/div busy countdown.
module hazard_sched
  import hz_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic           clk,
  input  logic           reset,
  hazard_sched_if.slave  hz
);

  localparam int MAXC =
    (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [CW-1:0] MULT_LD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LD  = CW'(DIV_CYCLES);

  slot_t         d_slot;
  slot_t         e_q;
  slot_t         m_q;
  slot_t         w_q;
  logic          stall;
  logic          stall_rs;
  logic          stall_rt;
  logic          md_nz;
  logic [CW-1:0] md_cnt;
  logic [1:0]    fwd_rs;
  logic [1:0]    fwd_rt;

  function automatic logic hit(
    input logic [4:0] r,
    input logic [1:0] t,
    input slot_t      s
  );
    return (t != TUSE_NONE) && (r != 5'd0) &&
           (r == s.dst) && (s.tnew > t);
  endfunction

  function automatic logic ready(
    input logic [4:0] r,
    input slot_t      s
  );
    return (r != 5'd0) && (r == s.dst) &&
           (s.tnew == TNEW_LINK);
  endfunction

  function automatic logic [1:0] fwd_sel(
    input logic [4:0] r,
    input slot_t      e,
    input slot_t      m,
    input slot_t      w
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (ready(r, e))      sel = FWD_E;
    else if (ready(r, m)) sel = FWD_M;
    else if (ready(r, w)) sel = FWD_W;
    return sel;
  endfunction

  assign d_slot = '{dst: hz.d_dst, tnew: hz.d_tnew};

  hz_slot u_e (
    .clk    (clk),
    .reset  (reset),
    .bubble (stall),
    .dec    (1'b0),
    .d      (d_slot),
    .q      (e_q)
  );

  hz_slot u_m (
    .clk    (clk),
    .reset  (reset),
    .bubble (1'b0),
    .dec    (1'b1),
    .d      (e_q),
    .q      (m_q)
  );

  hz_slot u_w (
    .clk    (clk),
    .reset  (reset),
    .bubble (1'b0),
    .dec    (1'b1),
    .d      (m_q),
    .q      (w_q)
  );

  assign stall_rs = hit(hz.d_rs, hz.d_tuse_rs, e_q) |
                    hit(hz.d_rs, hz.d_tuse_rs, m_q);
  assign stall_rt = hit(hz.d_rt, hz.d_tuse_rt, e_q) |
                    hit(hz.d_rt, hz.d_tuse_rt, m_q);
  assign md_nz    = (md_cnt != '0);
  assign stall    = stall_rs | stall_rt |
                    (hz.d_md_use & md_nz);
  assign fwd_rs   = fwd_sel(hz.d_rs, e_q, m_q, w_q);
  assign fwd_rt   = fwd_sel(hz.d_rt, e_q, m_q, w_q);

  // Pipeline controls; reset forces free-running fetch with bubbles
  always_comb begin
    hz.pc_en    = ~stall;
    hz.d_en     = ~stall;
    hz.e_clr    = stall;
    hz.fwd_rs_d = fwd_rs;
    hz.fwd_rt_d = fwd_rt;
    hz.md_busy  = md_nz;
    if (!reset) begin
      hz.pc_en    = 1'b1;
      hz.d_en     = 1'b1;
      hz.e_clr    = 1'b1;
      hz.fwd_rs_d = FWD_RF;
      hz.fwd_rt_d = FWD_RF;
      hz.md_busy  = 1'b0;
    end
  end

  // Mult/div busy countdown, loaded when the op leaves D
  always_ff @(posedge clk) begin
    if (!reset) begin
      md_cnt <= '0;
    end else if (hz.d_md_start && !stall) begin
      md_cnt <= hz.d_md_div ? DIV_LD : MULT_LD;
    end else if (md_nz) begin
      md_cnt <= md_cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_sched.sv
// Randomized scoreboard bench for hazard_sched against
// an instruction-timeline reference model.
module tb_hazard_sched;
  import hz_pkg::*;

  localparam int MULTC = 5;
  localparam int DIVC  = 10;

  typedef struct {
    logic [4:0] rs;
    logic [1:0] urs;
    logic [4:0] rt;
    logic [1:0] urt;
    logic [4:0] dst;
    logic [1:0] tnew;
    bit         ms;
    bit         mdiv;
    bit         muse;
  } din_t;

  typedef struct {
    int cyc;
    bit pc_en;
    bit d_en;
    bit e_clr;
    int fwd_rs;
    int fwd_rt;
    bit busy;
  } exp_t;

  typedef struct {
    int dst;
    int tnew;
    int ecyc;
  } ins_t;

  logic clk;
  logic reset;

  hazard_sched_if hz ();

  hazard_sched #(
    .MULT_CYCLES (MULTC),
    .DIV_CYCLES  (DIVC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   md_end = 0;
  ins_t inflight[$];
  exp_t expq[$];

  task automatic chk(input string nm, input int act,
                     input int req, input int c);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s cycle %0d got %0d want %0d",
               nm, c, act, req);
    end
  endtask

  function automatic din_t mk(int rs, int urs, int rt, int urt,
                              int dst, int tnew,
                              bit ms, bit mdiv, bit muse);
    din_t d;
    d.rs = 5'(rs); d.urs = 2'(urs);
    d.rt = 5'(rt); d.urt = 2'(urt);
    d.dst = 5'(dst); d.tnew = 2'(tnew);
    d.ms = ms; d.mdiv = mdiv; d.muse = muse;
    return d;
  endfunction

  function automatic din_t nop();
    return mk(0, 3, 0, 3, 0, 0, 0, 0, 0);
  endfunction

  function automatic din_t rnd();
    bit ms;
    ms = ($urandom_range(0, 7) == 0);
    return mk($urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 2),
              ms, 1'($urandom_range(0, 1)),
              ms || ($urandom_range(0, 5) == 0));
  endfunction

  // Operand r needed t cycles after D; producer has rem cycles left
  function automatic bit blocks(int r, int t, int dst, int rem);
    return t != 3 && r != 0 && r == dst && rem > t;
  endfunction

  function automatic exp_t model_eval(din_t d, bit rst_n);
    exp_t x;
    bit   st;
    int   fr;
    int   ft;
    st = cyc < md_end && d.muse;
    fr = 0;
    ft = 0;
    foreach (inflight[i]) begin
      int pos;
      int rem;
      pos = cyc - inflight[i].ecyc;
      rem = inflight[i].tnew - pos;
      if (rem < 0) rem = 0;
      if (pos <= 1) begin
        if (blocks(d.rs, d.urs, inflight[i].dst, rem)) st = 1;
        if (blocks(d.rt, d.urt, inflight[i].dst, rem)) st = 1;
      end
      if (pos <= 2 && rem == 0) begin
        if (d.rs != 0 && d.rs == inflight[i].dst &&
            (fr == 0 || pos + 1 < fr)) fr = pos + 1;
        if (d.rt != 0 && d.rt == inflight[i].dst &&
            (ft == 0 || pos + 1 < ft)) ft = pos + 1;
      end
    end
    x.cyc = cyc;
    if (!rst_n) begin
      x.pc_en = 1; x.d_en = 1; x.e_clr = 1;
      x.fwd_rs = 0; x.fwd_rt = 0; x.busy = 0;
    end else begin
      x.pc_en = !st; x.d_en = !st; x.e_clr = st;
      x.fwd_rs = fr; x.fwd_rt = ft;
      x.busy = cyc < md_end;
    end
    return x;
  endfunction

  function automatic void model_edge(din_t d, bit rst_n, bit st);
    if (!rst_n) begin
      inflight.delete();
      md_end = 0;
    end else begin
      while (inflight.size() > 0 &&
             cyc + 1 - inflight[0].ecyc > 2)
        void'(inflight.pop_front());
      if (!st) begin
        inflight.push_back('{dst: d.dst, tnew: d.tnew,
                             ecyc: cyc + 1});
        if (d.ms) md_end = cyc + 1 + (d.mdiv ? DIVC : MULTC);
      end
    end
    cyc++;
  endfunction

  task automatic drive(din_t d);
    hz.d_rs = d.rs; hz.d_tuse_rs = d.urs;
    hz.d_rt = d.rt; hz.d_tuse_rt = d.urt;
    hz.d_dst = d.dst; hz.d_tnew = d.tnew;
    hz.d_md_start = d.ms; hz.d_md_div = d.mdiv;
    hz.d_md_use = d.muse;
  endtask

  task automatic cyc_step(input din_t d, input bit rst_n,
                          output bit st, output bit dut_st);
    exp_t x;
    reset = rst_n;
    drive(d);
    x = model_eval(d, rst_n);
    st = !x.pc_en;
    expq.push_back(x);
    @(negedge clk);
    dut_st = (hz.pc_en == 1'b0);
    @(posedge clk);
    model_edge(d, rst_n, st);
    #1;
  endtask

  // Hold D until the model lets it go; count DUT stall cycles
  task automatic issue(input din_t d, input int want,
                       input string nm);
    bit st;
    bit ds;
    int n;
    n = 0;
    st = 1;
    for (int k = 0; k < 40 && st; k++) begin
      cyc_step(d, 1'b1, st, ds);
      if (ds) n++;
    end
    if (st) chk({nm, "_timeout"}, 1, 0, cyc);
    if (want >= 0) chk({nm, "_stalls"}, n, want, cyc);
  endtask

  // Monitor: every cycle presents a control word to check
  always @(negedge clk) begin
    exp_t e;
    if (expq.size() != 0) begin
      e = expq.pop_front();
      chk("pc_en",    int'(hz.pc_en),    int'(e.pc_en),  e.cyc);
      chk("d_en",     int'(hz.d_en),     int'(e.d_en),   e.cyc);
      chk("e_clr",    int'(hz.e_clr),    int'(e.e_clr),  e.cyc);
      chk("fwd_rs_d", int'(hz.fwd_rs_d), e.fwd_rs,       e.cyc);
      chk("fwd_rt_d", int'(hz.fwd_rt_d), e.fwd_rt,       e.cyc);
      chk("md_busy",  int'(hz.md_busy),  int'(e.busy),   e.cyc);
    end
  end

  initial begin
    bit st;
    bit ds;
    din_t div_op;
    din_t mflo;
    clk = 0;
    reset = 0;
    drive(nop());
    #1;
    for (int i = 0; i < 3; i++) cyc_step(rnd(), 1'b0, st, ds);

    issue(mk(0, 3, 0, 3, 1, TNEW_LOAD, 0, 0, 0), 0, "lw1");
    issue(mk(1, 1, 1, 1, 2, TNEW_ALU, 0, 0, 0), 1, "ld_use");
    repeat (3) issue(nop(), 0, "nop");

    issue(mk(0, 3, 0, 3, 3, TNEW_LOAD, 0, 0, 0), 0, "lw3");
    issue(mk(3, 0, 0, 0, 0, TNEW_LINK, 0, 0, 0), 2, "ld_br");
    issue(mk(0, 3, 0, 3, 5, TNEW_ALU, 0, 0, 0), 0, "alu5");
    issue(mk(5, 0, 0, 3, 0, TNEW_LINK, 0, 0, 0), 1, "alu_br");

    issue(mk(0, 3, 0, 3, 31, TNEW_LINK, 0, 0, 0), 0, "jal");
    issue(mk(31, 0, 0, 3, 0, TNEW_LINK, 0, 0, 0), 0, "jr");

    mflo = mk(0, 3, 0, 3, 4, TNEW_ALU, 0, 0, 1);
    issue(mk(6, 1, 7, 1, 0, 0, 1, 0, 1), 0, "mult");
    issue(mflo, MULTC, "mult_mflo");
    div_op = mk(6, 1, 7, 1, 0, 0, 1, 1, 1);
    issue(div_op, 0, "div");
    issue(mflo, DIVC, "div_mflo");

    issue(mk(0, 3, 0, 3, 0, TNEW_LOAD, 0, 0, 0), 0, "w0");
    issue(mk(0, 0, 0, 0, 0, 0, 0, 0, 0), 0, "r0");

    issue(div_op, 0, "div2");
    repeat (3) cyc_step(nop(), 1'b1, st, ds);
    cyc_step(mflo, 1'b0, st, ds);
    issue(mflo, 0, "rst_mflo");

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0)
        cyc_step(rnd(), 1'b0, st, ds);
      else
        issue(rnd(), -1, "rnd");
    end

    repeat (2) cyc_step(nop(), 1'b1, st, ds);
    @(negedge clk);
    #1;
    chk("drain", expq.size(), 0, cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
